// File: rtl/hop_chk_pkg.sv
// Shared types and defaults for the hop-lane checker: FSM state encoding,
// default geometry and the lane popcount used by the error accumulator.
package hop_chk_pkg;

  localparam int DEF_LANES   = 4;
  localparam int DEF_LATENCY = 4;
  localparam int DEF_WINDOW  = 256;
  localparam int DEF_CNT_W   = 16;
  localparam int POP_W       = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } hop_state_e;

  function automatic int unsigned popcount(input logic [POP_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_W; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/hop_lane_checker_if.sv
// Control/result bundle between the benchmark harness (master) and the
// hop-lane checker (slave).
interface hop_lane_checker_if #(
  parameter int LANES  = 4,
  parameter int WINDOW = 256,
  parameter int CNT_W  = 16
);
  localparam int CYC_W  = $clog2(WINDOW);
  localparam int LANE_W = $clog2(LANES);

  logic              arm;
  logic [LANES-1:0]  lane_mask;
  logic [LANES-1:0]  start_in;
  logic [LANES-1:0]  lane_out;
  logic              busy;
  logic              done;
  logic              pass;
  logic [CNT_W-1:0]  err_cnt;
  logic [LANES-1:0]  lane_err;
  logic [CYC_W-1:0]  first_err_cyc;
  logic [LANE_W-1:0] first_err_lane;

  modport master (
    output arm, lane_mask, start_in, lane_out,
    input  busy, done, pass, err_cnt, lane_err, first_err_cyc, first_err_lane
  );

  modport slave (
    input  arm, lane_mask, start_in, lane_out,
    output busy, done, pass, err_cnt, lane_err, first_err_cyc, first_err_lane
  );

endinterface

// File: rtl/hop_ref_delay.sv
// Reference delay line: the chain start bits delayed LATENCY cycles, giving
// the value each ideal flop chain should present at its output.
module hop_ref_delay #(
  parameter int LANES   = 4,
  parameter int LATENCY = 4
) (
  input  logic             clock0,
  input  logic             rst1,
  input  logic [LANES-1:0] din,
  output logic [LANES-1:0] dout
);

  logic [LATENCY-1:0][LANES-1:0] stage;

  // NOTE: this shift register is reset on purpose so a run started straight
  // after reset compares against zeros rather than X; plain storage arrays
  // elsewhere should not carry a reset.
  always_ff @(posedge clock0 or posedge rst1) begin
    if (rst1) begin
      stage <= '0;
    end else begin
      stage[0] <= din;
      for (int k = 1; k < LATENCY; k++) begin
        stage[k] <= stage[k-1];
      end
    end
  end

  assign dout = stage[LATENCY-1];

endmodule

// File: rtl/hop_lane_checker.sv
// Self-check for the multi-lane flop-chain benchmark: after arm, flush LATENCY
// cycles, compare WINDOW cycles against the reference line and hold the verdict.
module hop_lane_checker
  import hop_chk_pkg::*;
#(
  parameter int LANES   = DEF_LANES,
  parameter int LATENCY = DEF_LATENCY,
  parameter int WINDOW  = DEF_WINDOW,
  parameter int CNT_W   = DEF_CNT_W
) (
  input logic               clock0,
  input logic               rst1,
  hop_lane_checker_if.slave bus
);

  localparam int CYC_W  = $clog2(WINDOW);
  localparam int LANE_W = $clog2(LANES);
  localparam int FILL_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  hop_state_e        state;
  logic [LANES-1:0]  mask_q;
  logic [LANES-1:0]  exp_lanes;
  logic [LANES-1:0]  mis;
  logic [FILL_W-1:0] fill_cnt;
  logic [CYC_W-1:0]  cyc;
  logic [CNT_W-1:0]  err_cnt;
  logic [CNT_W-1:0]  err_next;
  logic [CNT_W-1:0]  headroom;
  logic [LANES-1:0]  lane_err;
  logic [CYC_W-1:0]  first_err_cyc;
  logic [LANE_W-1:0] first_err_lane;
  logic [LANE_W-1:0] low_lane;
  logic              busy;
  logic              done;
  logic              pass;
  int unsigned       pc;

  hop_ref_delay #(
    .LANES   (LANES),
    .LATENCY (LATENCY)
  ) u_ref (
    .clock0 (clock0),
    .rst1   (rst1),
    .din    (bus.start_in),
    .dout   (exp_lanes)
  );

  // NOTE: every variable gets a value before any conditional use so this
  // block cannot infer a latch.
  always_comb begin
    mis      = (exp_lanes ^ bus.lane_out) & mask_q;
    pc       = popcount(POP_W'(mis));
    headroom = CNT_MAX - err_cnt;
    err_next = (pc >= 32'(headroom)) ? CNT_MAX : err_cnt + CNT_W'(pc);
    low_lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mis[i]) low_lane = LANE_W'(i);
    end
  end

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clock0 or posedge rst1) begin
    if (rst1) begin
      state          <= IDLE;
      mask_q         <= '0;
      fill_cnt       <= '0;
      cyc            <= '0;
      err_cnt        <= '0;
      lane_err       <= '0;
      first_err_cyc  <= '0;
      first_err_lane <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.arm) begin
            state          <= FILL;
            mask_q         <= bus.lane_mask;
            fill_cnt       <= '0;
            cyc            <= '0;
            err_cnt        <= '0;
            lane_err       <= '0;
            first_err_cyc  <= '0;
            first_err_lane <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
          end
        end
        FILL: begin
          if (fill_cnt == FILL_W'(LATENCY - 1)) begin
            state <= CHECK;
            cyc   <= '0;
          end else begin
            fill_cnt <= fill_cnt + FILL_W'(1);
          end
        end
        CHECK: begin
          err_cnt  <= err_next;
          lane_err <= lane_err | mis;
          // lane_err still all-zero means no mismatch has been seen this run
          if ((|mis) && (lane_err == '0)) begin
            first_err_cyc  <= cyc;
            first_err_lane <= low_lane;
          end
          if (cyc == CYC_W'(WINDOW - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            cyc <= cyc + CYC_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy           = busy;
  assign bus.done           = done;
  assign bus.pass           = pass;
  assign bus.err_cnt        = err_cnt;
  assign bus.lane_err       = lane_err;
  assign bus.first_err_cyc  = first_err_cyc;
  assign bus.first_err_lane = first_err_lane;

endmodule
